// File: rtl/osd_spi_master.sv
// SPI initiator for the three-wire OSD command link (SCK, SS3, DO): enable/disable and line-write frames.
// Define OSD_SPI_CLEAR_EN to build cmd_type=3 (clear all: eight zero-filled write frames, lines 0..7).
module osd_spi_master #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned PAYLOAD_LEN = 256,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       req,
  input  logic [1:0] cmd_type,
  input  logic [2:0] cmd_line,
  output logic       busy,
  output logic       done,
  output logic       pay_rd,
  output logic [7:0] pay_addr,
  input  logic [7:0] pay_data,
  output logic       SPI_SCK,
  output logic       SPI_SS3,
  output logic       SPI_DO
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [8:0]  PAY_LEN  = 9'(PAYLOAD_LEN);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sck_q, sck_d;
  logic        ss3_q, ss3_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  nxt_q, nxt_d;
  logic [2:0]  bit_q, bit_d;
  logic [8:0]  left_q, left_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        cap_q, cap_d;
  logic [7:0]  addr_q, addr_d;
  logic        done_q, done_d;

  logic        legal;
  logic        last_frame;
  logic [7:0]  cmd_byte;

`ifdef OSD_SPI_CLEAR_EN
  logic        clr_q, clr_d;
  logic [2:0]  line_q, line_d;

  assign last_frame = !(clr_q && (line_q != 3'd7));
`else
  assign last_frame = 1'b1;
`endif

  always_comb begin
    cmd_byte = 8'h00;
    legal    = 1'b1;
    unique case (cmd_type)
      2'd0:    cmd_byte = 8'h40;
      2'd1:    cmd_byte = 8'h41;
      2'd2:    cmd_byte = {5'b00100, cmd_line};
      default: begin
        cmd_byte = 8'h20;
`ifdef OSD_SPI_CLEAR_EN
        legal    = 1'b1;
`else
        legal    = 1'b0;
`endif
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sck_d   = sck_q;
    sh_d    = sh_q;
    nxt_d   = nxt_q;
    bit_d   = bit_q;
    left_d  = left_q;
    wr_d    = wr_q;
    rd_d    = 1'b0;
    cap_d   = rd_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
`ifdef OSD_SPI_CLEAR_EN
    clr_d   = clr_q;
    line_d  = line_q;
`endif
    // The source answers one cycle after the strobe; grab it then.
    if (cap_q) nxt_d = pay_data;

    unique case (state_q)
      IDLE: begin
        sck_d = 1'b0;
        if (req && legal) begin
          sh_d    = cmd_byte;
          nxt_d   = '0;
          cnt_d   = '0;
          bit_d   = '0;
          addr_d  = '0;
          wr_d    = (cmd_type == 2'd2);
          left_d  = (cmd_type[1]) ? PAY_LEN : '0;
`ifdef OSD_SPI_CLEAR_EN
          clr_d   = (cmd_type == 2'd3);
          line_d  = '0;
`endif
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 16'd1;
        end else if (!sck_q) begin
          cnt_d = '0;
          sck_d = 1'b1;
          // Fetch the following byte on the first rise of each byte while any remain.
          if ((bit_q == 3'd0) && wr_q && (left_q != '0)) begin
            rd_d   = 1'b1;
            addr_d = 8'(PAY_LEN - left_q);
          end
        end else begin
          cnt_d = '0;
          sck_d = 1'b0;
          bit_d = bit_q + 3'd1;
          if ((bit_q == 3'd7) && (left_q != '0)) begin
            sh_d   = nxt_q;
            left_d = left_q - 9'd1;
          end else begin
            sh_d = {sh_q[6:0], 1'b0};
            if (bit_q == 3'd7) state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          done_d  = last_frame;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef OSD_SPI_CLEAR_EN
          if (!last_frame) begin
            line_d  = line_q + 3'd1;
            sh_d    = {5'b00100, line_q + 3'd1};
            left_d  = PAY_LEN;
            state_d = SETUP;
          end else begin
            clr_d = 1'b0;
          end
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    ss3_d = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sck_q   <= 1'b0;
      ss3_q   <= 1'b1;
      sh_q    <= '0;
      nxt_q   <= '0;
      bit_q   <= '0;
      left_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      cap_q   <= 1'b0;
      addr_q  <= '0;
      done_q  <= 1'b0;
`ifdef OSD_SPI_CLEAR_EN
      clr_q   <= 1'b0;
      line_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sck_q   <= sck_d;
      ss3_q   <= ss3_d;
      sh_q    <= sh_d;
      nxt_q   <= nxt_d;
      bit_q   <= bit_d;
      left_q  <= left_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cap_q   <= cap_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
`ifdef OSD_SPI_CLEAR_EN
      clr_q   <= clr_d;
      line_q  <= line_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign pay_rd   = rd_q;
  assign pay_addr = addr_q;
  assign SPI_SCK  = sck_q;
  assign SPI_SS3  = ss3_q;
  assign SPI_DO   = sh_q[7];

endmodule

// File: tb/tb_osd_spi_master.sv
// Bench for osd_spi_master: two instances (CLK_DIV=2/GAP=8 and CLK_DIV=1/GAP=3), PAYLOAD_LEN=4 each.
// Bytes seen on SCK rises are checked against a queue of expected frame bytes.
module tb_osd_spi_master;

  localparam int unsigned PAY   = 4;
  localparam int unsigned DIV_A = 2;
  localparam int unsigned GAP_A = 8;
  localparam int unsigned DIV_B = 1;
  localparam int unsigned GAP_B = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req_r = '0;
  logic [1:0] ctype_r [2];
  logic [2:0] line_r  [2];
  logic [7:0] pdat    [2];
  logic [1:0] busy_w, done_w, rd_w, sck_w, ss3_w, do_w;
  logic [7:0] addr_w  [2];

  always #5 clk = ~clk;

  osd_spi_master #(.CLK_DIV(DIV_A), .PAYLOAD_LEN(PAY), .GAP_CYCLES(GAP_A)) dut_a (
    .clk_sys(clk), .reset_n(rst_n), .req(req_r[0]), .cmd_type(ctype_r[0]), .cmd_line(line_r[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pay_rd(rd_w[0]), .pay_addr(addr_w[0]), .pay_data(pdat[0]),
    .SPI_SCK(sck_w[0]), .SPI_SS3(ss3_w[0]), .SPI_DO(do_w[0])
  );

  osd_spi_master #(.CLK_DIV(DIV_B), .PAYLOAD_LEN(PAY), .GAP_CYCLES(GAP_B)) dut_b (
    .clk_sys(clk), .reset_n(rst_n), .req(req_r[1]), .cmd_type(ctype_r[1]), .cmd_line(line_r[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pay_rd(rd_w[1]), .pay_addr(addr_w[1]), .pay_data(pdat[1]),
    .SPI_SCK(sck_w[1]), .SPI_SS3(ss3_w[1]), .SPI_DO(do_w[1])
  );

  // Line-buffer model: one-cycle read latency, contents 0xA0+addr.
  always @(posedge clk) begin
    if (rd_w[0]) pdat[0] <= 8'hA0 + addr_w[0];
    if (rd_w[1]) pdat[1] <= 8'hA0 + addr_w[1];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  logic [7:0] exp_q [$];

  int   cyc             = 0;
  int   low_cnt     [2] = '{default: 0};
  int   last_low    [2] = '{default: 0};
  int   frames      [2] = '{default: 0};
  int   rises       [2] = '{default: 0};
  int   rds         [2] = '{default: 0};
  int   rd_in_frame [2] = '{default: 0};
  int   dones       [2] = '{default: 0};
  int   bitn        [2] = '{default: 0};
  int   gap_hi      [2] = '{default: 0};
  int   last_gap    [2] = '{default: 0};
  int   done_cyc    [2] = '{default: 0};
  int   busy_lat    [2] = '{default: 0};
  int   viol        [2] = '{default: 0};
  logic [7:0] sr      [2] = '{default: 8'h00};
  logic prev_sck  [2] = '{default: 1'b0};
  logic prev_ss3  [2] = '{default: 1'b1};
  logic prev_do   [2] = '{default: 1'b0};
  logic prev_busy [2] = '{default: 1'b0};
  logic [7:0] eb;

  always @(negedge clk) begin
    cyc++;
    for (int unsigned i = 0; i < 2; i++) begin
      if (!rst_n) begin
        bitn[i]        = 0;
        low_cnt[i]     = 0;
        rd_in_frame[i] = 0;
      end else begin
        if (!ss3_w[i]) low_cnt[i]++;
        if (ss3_w[i] && !prev_ss3[i]) begin
          last_low[i] = low_cnt[i];
          low_cnt[i]  = 0;
          frames[i]++;
          gap_hi[i]   = 1;
        end else if (ss3_w[i]) begin
          gap_hi[i]++;
        end
        if (!ss3_w[i] && prev_ss3[i]) begin
          last_gap[i]    = gap_hi[i];
          rd_in_frame[i] = 0;
        end
        if (sck_w[i] && (do_w[i] != prev_do[i])) viol[i]++;
        if (sck_w[i] && !prev_sck[i]) begin
          rises[i]++;
          if (ss3_w[i]) viol[i]++;
          sr[i] = {sr[i][6:0], do_w[i]};
          bitn[i]++;
          if (bitn[i] == 8) begin
            bitn[i] = 0;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spi_byte: got 0x%02h expected no byte", sr[i]);
            end else begin
              eb = exp_q.pop_front();
              chk("spi_byte", int'(sr[i]), int'(eb));
            end
          end
        end
        if (rd_w[i]) begin
          chk("pay_addr", int'(addr_w[i]), rd_in_frame[i]);
          rd_in_frame[i]++;
          rds[i]++;
        end
        if (done_w[i]) begin
          dones[i]++;
          done_cyc[i] = cyc;
          chk("done_at_ss3_rise", int'({ss3_w[i], prev_ss3[i]}), 2);
        end
        if (!busy_w[i] && prev_busy[i]) busy_lat[i] = cyc - done_cyc[i];
      end
      prev_sck[i]  = sck_w[i];
      prev_ss3[i]  = ss3_w[i];
      prev_do[i]   = do_w[i];
      prev_busy[i] = busy_w[i];
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int unsigned i, input logic [1:0] t, input logic [2:0] ln);
    tick();
    req_r[i]   = 1'b1;
    ctype_r[i] = t;
    line_r[i]  = ln;
    tick();
    req_r[i]   = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned i, input int limit);
    int n = 0;
    while (busy_w[i] && (n < limit)) begin
      tick();
      n++;
    end
    if (busy_w[i]) chk("busy_timeout", int'(busy_w[i]), 0);
  endtask

  task automatic push_frame(input logic [7:0] cmd, input int unsigned nb, input logic zero);
    exp_q.push_back(cmd);
    for (int unsigned k = 0; k < nb; k++) exp_q.push_back(zero ? 8'h00 : 8'(8'hA0 + k));
  endtask

  typedef struct {
    int unsigned inst;
    logic [1:0]  ctype;
    logic [2:0]  line;
    logic        acc;
    int          nframes;
    int          low;
    int          nrise;
    int          nrd;
  } vec_t;

  vec_t vt [7];

  initial begin
    int unsigned i;
    int f0, r0, d0, q0, stray, n;
    logic clr_acc;

    ctype_r[0] = '0; ctype_r[1] = '0;
    line_r[0]  = '0; line_r[1]  = '0;
`ifdef OSD_SPI_CLEAR_EN
    clr_acc = 1'b1;
`else
    clr_acc = 1'b0;
`endif
    vt[0] = '{0, 2'd1, 3'd0, 1'b1, 1, 36,  8,  0};
    vt[1] = '{0, 2'd0, 3'd0, 1'b1, 1, 36,  8,  0};
    vt[2] = '{1, 2'd2, 3'd5, 1'b1, 1, 82,  40, 4};
    vt[3] = '{1, 2'd0, 3'd2, 1'b1, 1, 18,  8,  0};
    vt[4] = '{0, 2'd2, 3'd7, 1'b1, 1, 164, 40, 4};
    vt[5] = '{1, 2'd3, 3'd0, clr_acc, 8, 82, 320, 0};
    vt[6] = '{1, 2'd1, 3'd6, 1'b1, 1, 18,  8,  0};

    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_ss3",   int'(ss3_w),  3);
    chk("reset_sck",   int'(sck_w),  0);
    chk("reset_do",    int'(do_w),   0);
    chk("reset_busy",  int'(busy_w), 0);
    chk("reset_done",  int'(done_w), 0);
    chk("reset_pay_rd", int'(rd_w),  0);
    chk("reset_pay_addr", int'({addr_w[1], addr_w[0]}), 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_ss3",  int'(ss3_w),  3);
    chk("idle_sck",  int'(sck_w),  0);
    chk("idle_busy", int'(busy_w), 0);

    for (int unsigned v = 0; v < 7; v++) begin
      i  = vt[v].inst;
      f0 = frames[i]; r0 = rises[i]; d0 = dones[i]; q0 = rds[i];
      if (vt[v].acc) begin
        case (vt[v].ctype)
          2'd0: push_frame(8'h40, 0, 1'b0);
          2'd1: push_frame(8'h41, 0, 1'b0);
          2'd2: push_frame({5'b00100, vt[v].line}, PAY, 1'b0);
          default: for (int unsigned f = 0; f < 8; f++) push_frame(8'h20 | 8'(f), PAY, 1'b1);
        endcase
      end
      issue(i, vt[v].ctype, vt[v].line);
      chk($sformatf("v%0d_accept", v), int'(busy_w[i]), int'(vt[v].acc));
      if (vt[v].acc) begin
        wait_idle(i, 5000);
        chk($sformatf("v%0d_frames", v), frames[i] - f0, vt[v].nframes);
        chk($sformatf("v%0d_ss3_low", v), last_low[i], vt[v].low);
        chk($sformatf("v%0d_sck_rises", v), rises[i] - r0, vt[v].nrise);
        chk($sformatf("v%0d_pay_rd", v), rds[i] - q0, vt[v].nrd);
        chk($sformatf("v%0d_done", v), dones[i] - d0, 1);
        chk($sformatf("v%0d_busy_after_done", v), busy_lat[i], (i == 0) ? GAP_A : GAP_B);
        if (vt[v].nframes > 1) chk($sformatf("v%0d_inter_gap", v), last_gap[i], GAP_B);
      end else begin
        stray = 0;
        repeat (20) begin
          tick();
          if (busy_w[i] || !ss3_w[i]) stray++;
        end
        chk($sformatf("v%0d_stays_idle", v), stray, 0);
        chk($sformatf("v%0d_no_frame", v), frames[i] - f0, 0);
      end
      chk($sformatf("v%0d_bytes_drained", v), exp_q.size(), 0);
    end

    // req held through HOLD and GAP must be dropped; a fresh req right after busy falls is taken.
    f0 = frames[0]; r0 = rises[0]; d0 = dones[0];
    push_frame(8'h41, 0, 1'b0);
    issue(0, 2'd1, 3'd0);
    n = 0;
    while ((rises[0] - r0 < 8) && (n < 500)) begin tick(); n++; end
    chk("held_req_reach_last_bit", rises[0] - r0, 8);
    req_r[0] = 1'b1; ctype_r[0] = 2'd0;
    n = 0;
    while ((dones[0] == d0) && (n < 500)) begin tick(); n++; end
    chk("held_req_first_done", dones[0] - d0, 1);
    repeat (GAP_A - 2) tick();
    req_r[0] = 1'b0;
    wait_idle(0, 100);
    chk("held_req_frames", frames[0] - f0, 1);
    push_frame(8'h41, 0, 1'b0);
    issue(0, 2'd1, 3'd0);
    chk("back_to_back_accept", int'(busy_w[0]), 1);
    wait_idle(0, 500);
    chk("back_to_back_frames", frames[0] - f0, 2);
    chk("gap_at_least_min", int'(last_gap[0] >= GAP_A), 1);
    chk("held_req_bytes_drained", exp_q.size(), 0);

    // Reset in the middle of a write frame.
    d0 = dones[0];
    push_frame(8'h23, PAY, 1'b0);
    issue(0, 2'd2, 3'd3);
    repeat (40) tick();
    chk("midframe_ss3_low", int'(ss3_w[0]), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_ss3", int'(ss3_w[0]), 1);
    chk("async_reset_sck", int'(sck_w[0]), 0);
    chk("async_reset_busy", int'(busy_w[0]), 0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    repeat (10) tick();
    chk("midframe_reset_no_done", dones[0] - d0, 0);
    chk("midframe_reset_idle", int'(busy_w[0]), 0);

    chk("sck_do_rules_a", viol[0], 0);
    chk("sck_do_rules_b", viol[1], 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d checks done", checks);
    $fatal(1, "watchdog");
  end

endmodule
